// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the baud divider calculation
// used by both the receive and transmit sides.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int unsigned baud_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    return (clk_hz + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Oversample tick generator: counts 0..DIV-1 and pulses tick on DIV-1.
// A synchronous clear holds the counter at 0 so the tick phase can be aligned to an event.
module uart_tick_gen #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q == W'(DIV - 1)) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronized, oversampled, 3-sample majority vote per bit,
// one-entry holding register with valid/ack handshake, framing-error and overrun flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RxD,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned DIV = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] S_LO  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_HI  = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);

  logic          rxd_meta_q, rxd_sync_q;
  logic [1:0]    settle_q, settle_d;
  logic          line_high_q, line_high_d;
  rx_state_t     state_q, state_d;
  logic [SW-1:0] samp_cnt_q, samp_cnt_d;
  logic [1:0]    votes_q, votes_d;
  logic          bit_q, bit_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;

  logic tick, maj, start_edge, byte_done, ack_eff;

  uart_tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   ((state_q == IDLE) || (state_q == BREAK)),
    .tick  (tick)
  );

  // The synchronizer resets high, so it is only trusted once two real samples have
  // passed; this keeps a line that is low at reset release from looking like a start edge.
  assign settle_d    = {settle_q[0], 1'b1};
  assign line_high_d = settle_q[1] & rxd_sync_q;
  assign start_edge  = line_high_q & ~rxd_sync_q;

  assign maj     = (votes_q[0] & votes_q[1]) | (rxd_sync_q & (votes_q[0] | votes_q[1]));
  assign ack_eff = rx_ack & rx_valid_q;

  always_comb begin
    state_d     = state_q;
    samp_cnt_d  = samp_cnt_q;
    votes_d     = votes_q;
    bit_d       = bit_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    byte_done   = 1'b0;
    frame_err_d = 1'b0;

    if (tick) begin
      samp_cnt_d = (samp_cnt_q == S_END) ? '0 : samp_cnt_q + 1'b1;
      if (samp_cnt_q == S_LO)  votes_d[0] = rxd_sync_q;
      if (samp_cnt_q == S_MID) votes_d[1] = rxd_sync_q;
      if (samp_cnt_q == S_HI)  bit_d      = maj;
    end

    case (state_q)
      IDLE: begin
        samp_cnt_d = '0;
        bit_idx_d  = '0;
        if (start_edge) state_d = START;
      end
      START: begin
        if (tick && samp_cnt_q == S_HI && maj) state_d = IDLE;
        else if (tick && samp_cnt_q == S_END)  state_d = DATA;
      end
      DATA: begin
        if (tick && samp_cnt_q == S_END) begin
          shift_d   = {bit_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // Decide at mid-bit so the next start edge is seen with half a bit of margin.
        if (tick && samp_cnt_q == S_HI) begin
          if (maj) begin
            byte_done = 1'b1;
            state_d   = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end
      end
      BREAK: begin
        samp_cnt_d = '0;
        if (rxd_sync_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // An ack in the same cycle as a new byte frees the register for that byte.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    if (ack_eff) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end
    if (byte_done) begin
      if (!rx_valid_q || ack_eff) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta_q  <= 1'b1;
      rxd_sync_q  <= 1'b1;
      settle_q    <= '0;
      line_high_q <= 1'b0;
      state_q     <= IDLE;
      samp_cnt_q  <= '0;
      votes_q     <= '0;
      bit_q       <= 1'b0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rxd_meta_q  <= RxD;
      rxd_sync_q  <= rxd_meta_q;
      settle_q    <= settle_d;
      line_high_q <= line_high_d;
      state_q     <= state_d;
      samp_cnt_q  <= samp_cnt_d;
      votes_q     <= votes_d;
      bit_q       <= bit_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx: frames are generated at line level and the
// expected byte stream / error counts come from what was transmitted.
module tb_uart_rx;

  localparam int BIT_CLKS = 160;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       ack_auto = 1'b0;
  logic       ack_man = 1'b0;
  logic       auto_mode = 1'b1;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun;

  int         n_checks = 0;
  int         n_pass = 0;
  int         err_cycles = 0;
  int         exp_err = 0;
  logic [7:0] exp_q[$];

  assign rx_ack = ack_auto | ack_man;

  uart_rx #(.CLK_HZ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .RxD       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ack    (rx_ack),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time exceeded, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", tag, got, exp);
  endtask

  // Consumer: acks each byte on the first cycle it is seen and checks it against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      ack_auto = 1'b0;
    end else begin
      if (frame_err) err_cycles++;
      if (ack_auto) begin
        check_eq("valid_drop", rx_valid, 0);
        ack_auto = 1'b0;
      end else if (auto_mode && rx_valid) begin
        check_eq("byte_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check_eq("rx_data", rx_data, exp_q.pop_front());
        $display("rx byte %02h", rx_data);
        ack_auto = 1'b1;
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input int bclk, input logic stop_v);
    rxd = 1'b0;
    repeat (bclk) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (bclk) @(negedge clk);
    end
    rxd = stop_v;
    repeat (bclk) @(negedge clk);
    rxd = 1'b1;
  endtask

  // Model: a good stop bit delivers the byte, a low stop bit yields one frame_err cycle.
  task automatic send_expect(input logic [7:0] b, input int bclk, input logic stop_v);
    if (stop_v) exp_q.push_back(b);
    else        exp_err++;
    send_frame(b, bclk, stop_v);
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || rx_valid) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check_eq({tag, "_drain"}, exp_q.size(), 0);
    check_eq({tag, "_ferr"}, err_cycles, exp_err);
    check_eq({tag, "_ovr"}, overrun, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_data"}, rx_data, 8'h00);
    check_eq({tag, "_valid"}, rx_valid, 0);
    check_eq({tag, "_ferr"}, frame_err, 0);
    check_eq({tag, "_ovr"}, overrun, 0);
  endtask

  initial begin
    repeat (5) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
    idle(50);
    check_reset_vals("post_rst");

    // Single byte
    send_expect(8'hA5, BIT_CLKS, 1'b1);
    idle(100);
    drain("t1");

    // Back-to-back bytes, no idle gap
    send_expect(8'h00, BIT_CLKS, 1'b1);
    send_expect(8'hFF, BIT_CLKS, 1'b1);
    send_expect(8'h55, BIT_CLKS, 1'b1);
    idle(100);
    drain("t2");

    // Short low glitch must be rejected silently
    rxd = 1'b0;
    repeat (40) @(negedge clk);
    idle(2 * BIT_CLKS);
    drain("t3");

    // Framing error, then a clean byte
    send_expect(8'h3C, BIT_CLKS, 1'b0);
    idle(BIT_CLKS);
    check_eq("t4_valid_low", rx_valid, 0);
    send_expect(8'h81, BIT_CLKS, 1'b1);
    idle(100);
    drain("t4");

    // Overrun: no ack between two bytes
    auto_mode = 1'b0;
    send_frame(8'h11, BIT_CLKS, 1'b1);
    idle(50);
    send_frame(8'h22, BIT_CLKS, 1'b1);
    idle(50);
    check_eq("t5_valid", rx_valid, 1);
    check_eq("t5_data", rx_data, 8'h11);
    check_eq("t5_ovr", overrun, 1);
    ack_man = 1'b1;
    @(negedge clk);
    ack_man = 1'b0;
    check_eq("t5_valid_clr", rx_valid, 0);
    check_eq("t5_ovr_clr", overrun, 0);
    ack_man = 1'b1;
    @(negedge clk);
    ack_man = 1'b0;
    @(negedge clk);
    check_eq("t5_ack_idle_valid", rx_valid, 0);
    check_eq("t5_ack_idle_ovr", overrun, 0);
    check_eq("t5_data_held", rx_data, 8'h11);
    auto_mode = 1'b1;

    // Reset in the middle of a frame (during data bit 4 of 8'hC3)
    fork
      send_frame(8'hC3, BIT_CLKS, 1'b1);
      begin
        repeat (5 * BIT_CLKS + 40) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("t6_in_rst");
        repeat (20) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    idle(2 * BIT_CLKS);
    check_eq("t6_no_byte", rx_valid, 0);
    check_eq("t6_no_ferr", err_cycles, exp_err);
    send_expect(8'h7E, BIT_CLKS, 1'b1);
    idle(100);
    drain("t6");

    // Baud skew of about +/-3%
    send_expect(8'hA5, 155, 1'b1);
    idle(100);
    send_expect(8'hA5, 165, 1'b1);
    idle(100);
    drain("skew");

    // Random frames: random data, rate, gap and occasional bad stop bit
    for (int f = 0; f < 16; f++) begin
      logic [7:0] b;
      int         bclk;
      logic       good;
      b    = 8'($urandom);
      bclk = int'($urandom_range(156, 164));
      good = ($urandom_range(0, 7) != 0);
      send_expect(b, bclk, good);
      idle(good ? int'($urandom_range(0, 200)) : bclk + int'($urandom_range(0, 200)));
    end
    idle(100);
    drain("rand");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
